// File: rtl/hex_pair_reader.sv
// Recovers the byte shown on two active-low 7-segment digit buses once they hold steady.
// Optional sequence checker enabled by defining HEX_READER_SEQ_CHECK_EN.
module hex_pair_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  output logic       busy,
  output logic       valid,
  output logic [7:0] value,
  output logic       code_err,
  output logic       tmo,
  output logic       seq_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [8:0]  STABLE_LIM = 9'(STABLE_CYCLES);
  localparam logic [16:0] TMO_LIM    = 17'(TIMEOUT);

  state_t      state;
  logic [13:0] snap;
  logic [7:0]  scnt;
  logic [15:0] tcnt;

  logic [13:0] pair;
  logic [4:0]  dec1, dec0;
  logic [7:0]  new_val;
  logic        new_err;
  logic        same, accept, expire;

  // Returns {illegal, nibble}; an illegal glyph decodes to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   decode = 5'h00;
      7'h79:   decode = 5'h01;
      7'h24:   decode = 5'h02;
      7'h30:   decode = 5'h03;
      7'h19:   decode = 5'h04;
      7'h12:   decode = 5'h05;
      7'h02:   decode = 5'h06;
      7'h78:   decode = 5'h07;
      7'h00:   decode = 5'h08;
      7'h10:   decode = 5'h09;
      7'h08:   decode = 5'h0A;
      7'h03:   decode = 5'h0B;
      7'h46:   decode = 5'h0C;
      7'h21:   decode = 5'h0D;
      7'h06:   decode = 5'h0E;
      7'h0E:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    pair    = {hex1, hex0};
    dec1    = decode(snap[13:7]);
    dec0    = decode(snap[6:0]);
    new_val = {dec1[3:0], dec0[3:0]};
    new_err = dec1[4] | dec0[4];
    same    = (pair == snap);
    accept  = same && (({1'b0, scnt} + 9'd1) == STABLE_LIM);
    expire  = (({1'b0, tcnt} + 17'd1) == TMO_LIM);
  end

  // Handshake: req is a level examined only in IDLE; each accepted attempt
  // ends in exactly one of a one-cycle valid pulse or a one-cycle tmo pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      value    <= 8'h00;
      code_err <= 1'b0;
      tmo      <= 1'b0;
      snap     <= 14'h0;
      scnt     <= 8'h0;
      tcnt     <= 16'h0;
    end else begin
      valid <= 1'b0;
      tmo   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            snap  <= pair;
            scnt  <= 8'd1;
            tcnt  <= 16'd0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          tcnt <= tcnt + 16'd1;
          if (same) begin
            if (accept) begin
              value    <= new_val;
              code_err <= new_err;
              valid    <= 1'b1;
              state    <= REPORT;
            end else begin
              scnt <= scnt + 8'd1;
            end
          end else begin
            snap <= pair;
            scnt <= 8'd1;
          end
          // Acceptance wins over timeout on the same edge.
          if (expire && !accept) begin
            tmo   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

`ifdef HEX_READER_SEQ_CHECK_EN
  logic [7:0] prev;
  logic       have_prev;
  logic       seq_bad;

  always_comb begin
    seq_bad = have_prev && (new_val != prev) &&
              (new_val != 8'(prev + 8'd1)) && (new_val != 8'h00);
  end

  // Reads with an illegal glyph are not part of the sequence.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prev      <= 8'h00;
      have_prev <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if ((state == SETTLE) && accept && !new_err) begin
        seq_err   <= seq_bad;
        prev      <= new_val;
        have_prev <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_hex_pair_reader.sv
// Scoreboard bench for hex_pair_reader: directed reads, restart, blank glyph,
// timeout, back-to-back requests, reset mid-attempt and sequence reads.
module tb_hex_pair_reader;
  localparam int STABLE = 4;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic       req;
  logic [6:0] hex0, hex1;
  logic       busy, valid, code_err, tmo, seq_err;
  logic [7:0] value;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e_mon;

`ifdef HEX_READER_SEQ_CHECK_EN
  logic [7:0] m_prev = 8'h00;
  logic       m_have = 1'b0;
`endif

  hex_pair_reader #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .req(req), .hex0(hex0), .hex1(hex1),
    .busy(busy), .valid(valid), .value(value), .code_err(code_err),
    .tmo(tmo), .seq_err(seq_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] v, input logic err);
    logic s;
    s = 1'b0;
`ifdef HEX_READER_SEQ_CHECK_EN
    if (!err) begin
      s = m_have && (v != m_prev) && (v != 8'(m_prev + 8'd1)) && (v != 8'h00);
      m_prev = v;
      m_have = 1'b1;
    end
`endif
    exp_q.push_back({v, err, s});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
`ifdef HEX_READER_SEQ_CHECK_EN
    m_have = 1'b0;
`endif
  endtask

  // scoreboard: every valid pulse consumes one expected entry
  always @(negedge clk) begin
    if (clr && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("value", 32'(value), 32'(e_mon[9:2]));
        check("code_err", 32'(code_err), 32'(e_mon[1]));
        check("seq_err", 32'(seq_err), 32'(e_mon[0]));
      end
    end
    if (clr && !valid && seq_err) check("seq_err_stray", 32'(seq_err), 32'd0);
  end

  // driver: one request pulse, then measure capture-to-valid latency
  task automatic do_read(input logic [6:0] h1, input logic [6:0] h0,
                         input logic [7:0] v, input logic err);
    int edges;
    bit seen;
    @(negedge clk);
    hex1 = h1; hex0 = h0; req = 1'b1;
    push_exp(v, err);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    edges = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      edges++;
      if (valid) seen = 1'b1;
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(edges), 32'(STABLE - 1));
    @(negedge clk);
    check("valid_pulse", 32'(valid), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    int edges, n, first, gap;
    bit seen;
    clr = 1'b0; req = 1'b0; hex0 = 7'h40; hex1 = 7'h40;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_code_err", 32'(code_err), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    clr = 1'b1;
    repeat (2) @(negedge clk);

    do_read(7'h79, 7'h46, 8'h1C, 1'b0);

    // input change sampled at the second SETTLE edge restarts the count
    @(negedge clk);
    hex1 = 7'h40; hex0 = 7'h40; req = 1'b1;
    push_exp(8'h03, 1'b0);
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(posedge clk);
    @(negedge clk); hex0 = 7'h30;
    edges = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      edges++;
      if (valid) seen = 1'b1;
    end
    check("restart_seen", 32'(seen), 32'd1);
    check("restart_latency", 32'(edges), 32'd4);
    @(negedge clk);

    do_read(7'h40, 7'h7F, 8'h00, 1'b1);
    do_read(7'h08, 7'h12, 8'hA5, 1'b0);

    // inputs never settle: timeout after TMO edges, value retained
    @(negedge clk);
    hex1 = 7'h40; hex0 = 7'h40; req = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0; hex0 = 7'h79;
    edges = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      edges++;
      if (tmo) seen = 1'b1;
      else hex0 = (hex0 == 7'h40) ? 7'h79 : 7'h40;
    end
    check("tmo_seen", 32'(seen), 32'd1);
    check("tmo_edges", 32'(edges), 32'(TMO));
    check("tmo_value_kept", 32'(value), 32'hA5);
    check("tmo_err_kept", 32'(code_err), 32'd0);
    @(negedge clk);
    check("tmo_pulse", 32'(tmo), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);

    // held request: one valid every STABLE+1 cycles
    @(negedge clk);
    hex1 = 7'h19; hex0 = 7'h24; req = 1'b1;
    push_exp(8'h42, 1'b0);
    push_exp(8'h42, 1'b0);
    edges = 0; n = 0; first = 0; gap = 0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      @(posedge clk); @(negedge clk);
      edges++;
      if (valid) begin
        n++;
        if (n == 1) first = edges;
        else gap = edges - first;
      end
    end
    req = 1'b0;
    check("cont_valids", 32'(n), 32'd2);
    check("cont_period", 32'(gap), 32'(STABLE + 1));
    repeat (2) @(negedge clk);

    // asynchronous reset mid-SETTLE
    @(negedge clk);
    hex1 = 7'h79; hex0 = 7'h79; req = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_value", 32'(value), 32'd0);
    check("clr_code_err", 32'(code_err), 32'd0);
    check("clr_tmo", 32'(tmo), 32'd0);
    check("clr_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
`ifdef HEX_READER_SEQ_CHECK_EN
    m_have = 1'b0;
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_clr_busy", 32'(busy), 32'd0);
      check("post_clr_tmo", 32'(tmo), 32'd0);
    end

    // sequence reads
    do_read(7'h19, 7'h79, 8'h41, 1'b0);
    do_read(7'h19, 7'h24, 8'h42, 1'b0);
    do_read(7'h19, 7'h24, 8'h42, 1'b0);
    do_read(7'h19, 7'h19, 8'h44, 1'b0);
    do_read(7'h40, 7'h40, 8'h00, 1'b0);
    pulse_reset();
    do_read(7'h0E, 7'h0E, 8'hFF, 1'b0);
    do_read(7'h40, 7'h40, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
